// File: rtl/gpu_dmem_dma.sv
// gpu_dmem_dma: moves word blocks between a valid/ready stream and one
// synchronous dmem port. dir=0 streams s_* words into dmem, dir=1 streams
// dmem words out on m_*. Optional counters: define GPU_DMEM_DMA_PERF_EN to
// add perf_words / perf_stall.

`ifndef GPU_DMEM_ADDR_WIDTH
`define GPU_DMEM_ADDR_WIDTH 8
`endif
`ifndef GPU_DMEM_DATA_WIDTH
`define GPU_DMEM_DATA_WIDTH 32
`endif

module gpu_dmem_dma #(
    parameter int LEN_W = `GPU_DMEM_ADDR_WIDTH + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_dir,
    input  logic [`GPU_DMEM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]                cmd_len,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [`GPU_DMEM_DATA_WIDTH-1:0] s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [`GPU_DMEM_DATA_WIDTH-1:0] m_data,
    output logic [`GPU_DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [`GPU_DMEM_DATA_WIDTH-1:0] mem_din,
    output logic                            mem_we,
    input  logic [`GPU_DMEM_DATA_WIDTH-1:0] mem_dout,
    output logic                            busy,
    output logic                            done
`ifdef GPU_DMEM_DMA_PERF_EN
    ,
    output logic [31:0]                     perf_words,
    output logic [31:0]                     perf_stall
`endif
);

    localparam int AW = `GPU_DMEM_ADDR_WIDTH;
    localparam int DW = `GPU_DMEM_DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     base_reg, base_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  idx_reg, idx_next;
    logic              inflight_reg;
    logic [1:0]        fifo_cnt_reg;
    logic              wr_ptr_reg, rd_ptr_reg;
    logic [DW-1:0]     fifo_mem [2];

    logic [AW-1:0]     addr_cur;
    logic              idx_last;
    logic              fifo_nonempty;
    logic              pop, pop_fifo, push;
    logic [2:0]        occ_after;
    logic              rd_issue;

    // Address wraps naturally by truncation to AW bits.
    assign addr_cur      = base_reg + AW'(idx_reg);
    assign idx_last      = (idx_reg == len_reg - LEN_W'(1));
    assign fifo_nonempty = (fifo_cnt_reg != 2'd0);

    // When the buffer is empty, the word returning from dmem is offered
    // directly; if it is not taken it lands in the buffer and is re-offered
    // unchanged from there, so m_data stays stable across stalls.
    assign m_valid  = fifo_nonempty || inflight_reg;
    assign m_data   = fifo_nonempty ? fifo_mem[rd_ptr_reg] : mem_dout;
    assign pop      = m_valid && m_ready;
    assign pop_fifo = pop && fifo_nonempty;
    assign push     = inflight_reg && !(pop && !fifo_nonempty);

    // Credit test counts this cycle's pop so a full-rate stream keeps flowing
    // while buffered + outstanding words never exceed two.
    assign occ_after = 3'(fifo_cnt_reg) + 3'(inflight_reg) - 3'(pop);
    assign rd_issue  = (state_reg == ST_READ) && (occ_after < 3'd2);

    // Next-state and output decode.
    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    base_next = cmd_addr;
                    len_next  = cmd_len;
                    idx_next  = '0;
                    if (cmd_len == '0) begin
                        state_next = ST_DONE;
                    end else if (cmd_dir) begin
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                s_ready  = 1'b1;
                mem_addr = addr_cur;
                if (s_valid) begin
                    mem_we   = 1'b1;
                    mem_din  = s_data;
                    idx_next = idx_reg + LEN_W'(1);
                    if (idx_last) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                mem_addr = addr_cur;
                if (rd_issue) begin
                    idx_next = idx_reg + LEN_W'(1);
                    if (idx_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Last word leaves when exactly one word remains and it is taken.
                if (pop && (3'(fifo_cnt_reg) + 3'(inflight_reg) == 3'd1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control state, command registers and read-buffer bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            base_reg     <= '0;
            len_reg      <= '0;
            idx_reg      <= '0;
            inflight_reg <= 1'b0;
            fifo_cnt_reg <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            len_reg      <= len_next;
            idx_reg      <= idx_next;
            inflight_reg <= rd_issue;
            fifo_cnt_reg <= fifo_cnt_reg + 2'(push) - 2'(pop_fifo);
            wr_ptr_reg   <= wr_ptr_reg ^ push;
            rd_ptr_reg   <= rd_ptr_reg ^ pop_fifo;
        end
    end

    // Read-buffer storage; validity is tracked by fifo_cnt_reg alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mem_dout;
        end
    end

`ifdef GPU_DMEM_DMA_PERF_EN
    logic mem_access;
    assign mem_access = mem_we || rd_issue;

    // Saturating activity counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_words <= '0;
            perf_stall <= '0;
        end else begin
            if (mem_access && (perf_words != '1)) begin
                perf_words <= perf_words + 32'd1;
            end
            if (busy && !mem_access && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
